cpu4_sequencer: RTL and testbench

Fetch/execute controller for the 4-bit microprocessor. It fetches 8-bit instructions from program memory over a valid handshake and drives opcode and operands into the ALU. It pulses the write enables of the flag register and the accumulator, and takes conditional branches from the Carry/Zero/Sign/Parity flags. It sits between instruction memory and the ALU + flag register pair and is the only block that sequences them.

---
 rtl/cpu4_pkg.sv | 45 ++++
 rtl/cpu4_sequencer_if.sv | 32 +++
 rtl/cpu4_branch_unit.sv | 26 ++
 rtl/cpu4_sequencer.sv | 179 +++++++++++++++++
 tb/tb_cpu4_sequencer.sv | 396 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu4_pkg.sv
// cpu4_pkg: shared definitions for the 4-bit CPU sequencer.
//   - opcode constants (OP_NOP .. OP_HLT)
//   - flag bit indices into the flag register (FLG_C/Z/S/P)
//   - sequencer state encoding (enum typedef plus plain constants)
//   - small opcode classification helper
package cpu4_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_LDI = 4'h6;
  localparam logic [3:0] OP_JMP = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_JC  = 4'h9;
  localparam logic [3:0] OP_JS  = 4'hA;
  localparam logic [3:0] OP_JP  = 4'hB;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int FLG_C = 0;
  localparam int FLG_Z = 1;
  localparam int FLG_S = 2;
  localparam int FLG_P = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  // Plain constants with the same encoding as state_e, used by the FSM.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  // True for the opcodes that go through the ALU and update the flags.
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_XOR);
  endfunction

endpackage

// File: rtl/cpu4_sequencer_if.sv
// cpu4_sequencer_if: bus between the sequencer and its neighbours.
//   imem_req/imem_addr  : fetch request and address (sequencer -> memory)
//   imem_valid/imem_data: fetch response (memory -> sequencer)
//   alu_opcode/a/b      : operation and operands (sequencer -> ALU/flags)
//   alu_result          : combinational ALU result (ALU -> sequencer)
//   flags               : flag register contents (flags -> sequencer)
//   flag_we             : flag register capture strobe (sequencer -> flags)
// master = sequencer side, slave = memory/ALU/flag-register side.
interface cpu4_sequencer_if #(
  parameter int PC_W = 4
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_valid;
  logic [7:0]      imem_data;
  logic [3:0]      alu_opcode;
  logic [3:0]      alu_a;
  logic [3:0]      alu_b;
  logic [3:0]      alu_result;
  logic [3:0]      flags;
  logic            flag_we;

  modport master (
    output imem_req, imem_addr, alu_opcode, alu_a, alu_b, flag_we,
    input  imem_valid, imem_data, alu_result, flags
  );

  modport slave (
    input  imem_req, imem_addr, alu_opcode, alu_a, alu_b, flag_we,
    output imem_valid, imem_data, alu_result, flags
  );
endinterface

// File: rtl/cpu4_branch_unit.sv
// cpu4_branch_unit: combinational branch decision.
//   opcode_i : opcode of the instruction in EXEC
//   flags_i  : flag register ([0] C, [1] Z, [2] S, [3] P)
//   taken_o  : 1 when the instruction is a branch whose condition holds
module cpu4_branch_unit
  import cpu4_pkg::*;
(
  input  logic [3:0] opcode_i,
  input  logic [3:0] flags_i,
  output logic       taken_o
);

  // Select the condition flag for the branch opcode; non-branches never take.
  always_comb begin
    taken_o = 1'b0;
    case (opcode_i)
      OP_JMP:  taken_o = 1'b1;
      OP_JZ:   taken_o = flags_i[FLG_Z];
      OP_JC:   taken_o = flags_i[FLG_C];
      OP_JS:   taken_o = flags_i[FLG_S];
      OP_JP:   taken_o = flags_i[FLG_P];
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu4_sequencer.sv
// cpu4_sequencer: fetch/execute controller for the 4-bit CPU.
//   Clk, Rst : clock and synchronous active-high reset
//   Start    : leave IDLE and start fetching at pc=0
//   bus      : memory fetch handshake and ALU/flag-register signals
//   acc      : accumulator
//   pc       : program counter (also the fetch address)
//   halted   : sticky, set by HLT
//   illegal  : sticky, set by an undefined opcode (0xC-0xE)
// Sequence: IDLE -> FETCH (req held until valid) -> EXEC -> FETCH ... / HALT.
// ALU controls and flag_we are registered on the FETCH->EXEC edge so they
// are valid for the whole EXEC cycle and drop back to zero on leaving it.
module cpu4_sequencer
  import cpu4_pkg::*;
#(
  parameter int PC_W = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  cpu4_sequencer_if.master bus,
  output logic [3:0]       acc,
  output logic [PC_W-1:0]  pc,
  output logic             halted,
  output logic             illegal
);

  logic [1:0]      state_q,      state_d;
  logic [PC_W-1:0] pc_q,         pc_d;
  logic [3:0]      acc_q,        acc_d;
  logic [7:0]      ir_q,         ir_d;
  logic            imem_req_q,   imem_req_d;
  logic [3:0]      alu_opcode_q, alu_opcode_d;
  logic [3:0]      alu_b_q,      alu_b_d;
  logic            flag_we_q,    flag_we_d;
  logic            halted_q,     halted_d;
  logic            illegal_q,    illegal_d;

  logic [3:0]      fetch_op_s;
  logic [3:0]      ir_op_s;
  logic [3:0]      ir_imm_s;
  logic [PC_W-1:0] pc_inc_s;
  logic [PC_W-1:0] target_s;
  logic            taken_s;

  assign fetch_op_s = bus.imem_data[7:4];
  assign ir_op_s    = ir_q[7:4];
  assign ir_imm_s   = ir_q[3:0];
  assign pc_inc_s   = pc_q + PC_W'(1'b1);
  assign target_s   = PC_W'(ir_imm_s);

  cpu4_branch_unit u_branch (
    .opcode_i (ir_op_s),
    .flags_i  (bus.flags),
    .taken_o  (taken_s)
  );

  // Next-state logic for the FSM, PC, IR, accumulator and ALU controls.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    acc_d        = acc_q;
    ir_d         = ir_q;
    imem_req_d   = imem_req_q;
    alu_opcode_d = alu_opcode_q;
    alu_b_d      = alu_b_q;
    flag_we_d    = flag_we_q;
    halted_d     = halted_q;
    illegal_d    = illegal_q;

    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d    = ST_FETCH;
          imem_req_d = 1'b1;
        end else begin
          state_d    = ST_IDLE;
        end
      end

      ST_FETCH: begin
        // A response only counts while our request is actually up.
        if (imem_req_q && bus.imem_valid) begin
          state_d    = ST_EXEC;
          ir_d       = bus.imem_data;
          imem_req_d = 1'b0;
          if (is_alu_op(fetch_op_s)) begin
            alu_opcode_d = fetch_op_s;
            alu_b_d      = bus.imem_data[3:0];
            flag_we_d    = 1'b1;
          end else begin
            alu_opcode_d = OP_NOP;
            alu_b_d      = 4'h0;
            flag_we_d    = 1'b0;
          end
        end else begin
          state_d = ST_FETCH;
        end
      end

      ST_EXEC: begin
        alu_opcode_d = OP_NOP;
        alu_b_d      = 4'h0;
        flag_we_d    = 1'b0;
        state_d      = ST_FETCH;
        imem_req_d   = 1'b1;
        pc_d         = pc_inc_s;
        case (ir_op_s)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: acc_d = bus.alu_result;
          OP_LDI: acc_d = ir_imm_s;
          OP_JMP, OP_JZ, OP_JC, OP_JS, OP_JP: begin
            if (taken_s) begin
              pc_d = target_s;
            end else begin
              pc_d = pc_inc_s;
            end
          end
          OP_HLT: begin
            state_d    = ST_HALT;
            imem_req_d = 1'b0;
            pc_d       = pc_q;
            halted_d   = 1'b1;
          end
          OP_NOP:  acc_d = acc_q;
          // 0xC-0xE: behave as NOP but record the event.
          default: illegal_d = 1'b1;
        endcase
      end

      ST_HALT: begin
        state_d    = ST_HALT;
        imem_req_d = 1'b0;
      end

      default: begin
        state_d    = ST_IDLE;
        imem_req_d = 1'b0;
      end
    endcase
  end

  // State registers; Rst overrides every other input.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= ST_IDLE;
      pc_q         <= '0;
      acc_q        <= 4'h0;
      ir_q         <= 8'h00;
      imem_req_q   <= 1'b0;
      alu_opcode_q <= 4'h0;
      alu_b_q      <= 4'h0;
      flag_we_q    <= 1'b0;
      halted_q     <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      acc_q        <= acc_d;
      ir_q         <= ir_d;
      imem_req_q   <= imem_req_d;
      alu_opcode_q <= alu_opcode_d;
      alu_b_q      <= alu_b_d;
      flag_we_q    <= flag_we_d;
      halted_q     <= halted_d;
      illegal_q    <= illegal_d;
    end
  end

  assign bus.imem_req   = imem_req_q;
  assign bus.imem_addr  = pc_q;
  assign bus.alu_opcode = alu_opcode_q;
  assign bus.alu_a      = acc_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.flag_we    = flag_we_q;
  assign acc            = acc_q;
  assign pc             = pc_q;
  assign halted         = halted_q;
  assign illegal        = illegal_q;

endmodule

// File: tb/tb_cpu4_sequencer.sv
// tb_cpu4_sequencer: self-checking bench for cpu4_sequencer.
// The bench provides program memory, a behavioural ALU and the flag register.
// Each delivered instruction is stepped through an ISA model and the expected
// architectural state is queued; the test tasks pop and compare after retire.
module tb_cpu4_sequencer;
  import cpu4_pkg::*;

  localparam int PC_W = 4;

  typedef struct {
    logic [3:0] addr;
    logic [3:0] pc;
    logic [3:0] acc;
    logic [3:0] op;
    logic [3:0] b;
    logic       we;
    logic       halted;
    logic       illegal;
  } exp_t;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       Start;
  logic [3:0] acc;
  logic [3:0] pc;
  logic       halted;
  logic       illegal;

  cpu4_sequencer_if #(.PC_W(PC_W)) bus ();

  cpu4_sequencer #(.PC_W(PC_W)) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .Start   (Start),
    .bus     (bus),
    .acc     (acc),
    .pc      (pc),
    .halted  (halted),
    .illegal (illegal)
  );

  always #5 Clk = ~Clk;

  // ALU: returns {carry, result}. SUB carry means borrow.
  function automatic logic [4:0] alu_fn(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      OP_ADD:  return {1'b0, a} + {1'b0, b};
      OP_SUB:  return {(a < b), a - b};
      OP_AND:  return {1'b0, a & b};
      OP_OR:   return {1'b0, a | b};
      OP_XOR:  return {1'b0, a ^ b};
      default: return 5'h00;
    endcase
  endfunction

  // Flags {P(even parity), S, Z, C} from an ALU outcome.
  function automatic logic [3:0] flag_fn(input logic [4:0] f);
    logic [3:0] r;
    r = f[3:0];
    return {~^r, r[3], (r == 4'h0), f[4]};
  endfunction

  logic [4:0] alu_full_s;
  logic [3:0] flag_q;
  assign alu_full_s     = alu_fn(bus.alu_opcode, bus.alu_a, bus.alu_b);
  assign bus.alu_result = alu_full_s[3:0];
  assign bus.flags      = flag_q;

  always @(posedge Clk) begin
    if (Rst) flag_q <= 4'h0;
    else if (bus.flag_we) flag_q <= flag_fn(alu_full_s);
  end

  int cyc = 0;
  int we_pulses = 0;
  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (bus.flag_we === 1'b1) we_pulses <= we_pulses + 1;
  end

  logic [7:0] mem [16];
  exp_t       sb_q [$];
  logic [3:0] ref_pc, ref_acc, ref_flags;
  logic       ref_halted, ref_illegal;
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic do_reset();
    Rst = 1'b1; Start = 1'b0; bus.imem_valid = 1'b0; bus.imem_data = 8'h00;
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    ref_pc = 4'h0; ref_acc = 4'h0; ref_flags = 4'h0; ref_halted = 1'b0; ref_illegal = 1'b0;
    sb_q.delete();
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  // Serves one fetch (after 'waits' extra cycles), steps the ISA model and
  // queues the expectation. Returns at the negedge after EXEC.
  task automatic fetch_one(input int waits, input bit spurious, input bit rst_exec,
                           output bit ok, output int stable, output int dcyc,
                           output logic sw, output logic [3:0] sop, output logic [3:0] sb,
                           output logic [3:0] saddr);
    int t;
    logic [7:0] instr;
    logic [3:0] op, imm;
    logic [4:0] af;
    exp_t e;
    t = 0; ok = 1'b0; stable = 0; dcyc = 0; sw = 1'b0; sop = 4'h0; sb = 4'h0; saddr = 4'h0;
    while (bus.imem_req !== 1'b1 && t < 20) begin
      @(negedge Clk);
      t++;
    end
    if (bus.imem_req !== 1'b1) return;
    ok = 1'b1;
    saddr = bus.imem_addr;
    for (int i = 0; i <= waits; i++) begin
      if (bus.imem_req === 1'b1 && bus.imem_addr === saddr) stable++;
      @(negedge Clk);
    end
    if (bus.imem_req === 1'b1 && bus.imem_addr === saddr) stable++;
    instr = mem[saddr];
    bus.imem_valid = 1'b1;
    bus.imem_data  = instr;
    if (!rst_exec) begin
      op = instr[7:4]; imm = instr[3:0];
      e.addr = ref_pc;
      e.we   = (op >= OP_ADD) && (op <= OP_XOR);
      e.op   = e.we ? op : 4'h0;
      e.b    = e.we ? imm : 4'h0;
      case (op)
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
          af = alu_fn(op, ref_acc, imm);
          ref_acc = af[3:0]; ref_flags = flag_fn(af); ref_pc = ref_pc + 4'h1;
        end
        OP_LDI: begin ref_acc = imm; ref_pc = ref_pc + 4'h1; end
        OP_JMP: ref_pc = imm;
        OP_JZ:  ref_pc = ref_flags[FLG_Z] ? imm : ref_pc + 4'h1;
        OP_JC:  ref_pc = ref_flags[FLG_C] ? imm : ref_pc + 4'h1;
        OP_JS:  ref_pc = ref_flags[FLG_S] ? imm : ref_pc + 4'h1;
        OP_JP:  ref_pc = ref_flags[FLG_P] ? imm : ref_pc + 4'h1;
        OP_HLT: ref_halted = 1'b1;
        4'hC, 4'hD, 4'hE: begin ref_illegal = 1'b1; ref_pc = ref_pc + 4'h1; end
        default: ref_pc = ref_pc + 4'h1;
      endcase
      e.pc = ref_pc; e.acc = ref_acc; e.halted = ref_halted; e.illegal = ref_illegal;
      sb_q.push_back(e);
    end
    @(negedge Clk);
    dcyc = cyc;
    sw = bus.flag_we; sop = bus.alu_opcode; sb = bus.alu_b;
    if (spurious) begin
      bus.imem_data = 8'h6F;
    end else begin
      bus.imem_valid = 1'b0; bus.imem_data = 8'h00;
    end
    if (rst_exec) Rst = 1'b1;
    @(negedge Clk);
    bus.imem_valid = 1'b0; bus.imem_data = 8'h00;
  endtask

  task automatic test_reset();
    int req_hi;
    Rst = 1'b1; Start = 1'b0; bus.imem_valid = 1'b1; bus.imem_data = 8'h6F;
    repeat (2) @(negedge Clk);
    n_cmp++;
    if ({bus.imem_req, bus.imem_addr, bus.flag_we, bus.alu_opcode, bus.alu_a, bus.alu_b,
         acc, pc, halted, illegal} !== 28'h0) begin
      n_bad++;
      $display("FAIL reset_state: req=%b addr=%h we=%b op=%h a=%h b=%h acc=%h pc=%h halted=%b illegal=%b, expected all zero",
               bus.imem_req, bus.imem_addr, bus.flag_we, bus.alu_opcode, bus.alu_a, bus.alu_b, acc, pc, halted, illegal);
    end
    Rst = 1'b0;
    req_hi = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (i == 2) bus.imem_valid = 1'b0;
      if (bus.imem_req !== 1'b0) req_hi++;
    end
    n_cmp++;
    if (req_hi != 0 || acc !== 4'h0 || pc !== 4'h0) begin
      n_bad++;
      $display("FAIL idle_no_req: req high %0d cycles acc=%h pc=%h, expected 0 cycles acc=0 pc=0", req_hi, acc, pc);
    end
  endtask

  task automatic test_alu_carry();
    bit ok; int stable, dcyc, prev, w0; logic sw; logic [3:0] sop, sb, saddr; exp_t e;
    do_reset();
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[0] = 8'h69; mem[1] = 8'h18; mem[2] = 8'h95;
    pulse_start();
    w0 = we_pulses; prev = 0;
    for (int k = 0; k < 3; k++) begin
      fetch_one(0, 1'b0, 1'b0, ok, stable, dcyc, sw, sop, sb, saddr);
      n_cmp++;
      if (!ok || sb_q.size() == 0) begin
        n_bad++; $display("FAIL carry_fetch[%0d]: no fetch request within bound, req=%b expected 1", k, bus.imem_req);
      end else begin
        e = sb_q.pop_front();
        if ({saddr, pc, acc, halted, illegal} !== {e.addr, e.pc, e.acc, e.halted, e.illegal}) begin
          n_bad++; $display("FAIL carry_retire[%0d]: addr=%h pc=%h acc=%h h=%b i=%b, expected addr=%h pc=%h acc=%h h=%b i=%b",
                            k, saddr, pc, acc, halted, illegal, e.addr, e.pc, e.acc, e.halted, e.illegal);
        end
        n_cmp++;
        if ({sw, sop, sb} !== {e.we, e.op, e.b}) begin
          n_bad++; $display("FAIL carry_exec[%0d]: we=%b op=%h b=%h, expected we=%b op=%h b=%h", k, sw, sop, sb, e.we, e.op, e.b);
        end
        if (k > 0) begin
          n_cmp++;
          if (dcyc - prev != 3) begin n_bad++; $display("FAIL carry_cadence[%0d]: %0d cycles, expected 3", k, dcyc - prev); end
        end
        prev = dcyc;
      end
    end
    n_cmp++;
    if (we_pulses - w0 != 1 || acc !== 4'h1 || pc !== 4'h5) begin
      n_bad++; $display("FAIL carry_summary: we_pulses=%0d acc=%h pc=%h, expected 1 acc=1 pc=5", we_pulses - w0, acc, pc);
    end
  endtask

  task automatic test_branch_halt();
    bit ok; int stable, dcyc, prev, req_hi; logic sw; logic [3:0] sop, sb, saddr; exp_t e;
    do_reset();
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[0] = 8'h63; mem[1] = 8'h23; mem[2] = 8'h8C; mem[12] = 8'hF0;
    pulse_start();
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      fetch_one(0, 1'b0, 1'b0, ok, stable, dcyc, sw, sop, sb, saddr);
      n_cmp++;
      if (!ok || sb_q.size() == 0) begin
        n_bad++; $display("FAIL halt_fetch[%0d]: no fetch request within bound, req=%b expected 1", k, bus.imem_req);
      end else begin
        e = sb_q.pop_front();
        if ({saddr, pc, acc, halted, illegal} !== {e.addr, e.pc, e.acc, e.halted, e.illegal}) begin
          n_bad++; $display("FAIL halt_retire[%0d]: addr=%h pc=%h acc=%h h=%b i=%b, expected addr=%h pc=%h acc=%h h=%b i=%b",
                            k, saddr, pc, acc, halted, illegal, e.addr, e.pc, e.acc, e.halted, e.illegal);
        end
        n_cmp++;
        if ({sw, sop, sb} !== {e.we, e.op, e.b}) begin
          n_bad++; $display("FAIL halt_exec[%0d]: we=%b op=%h b=%h, expected we=%b op=%h b=%h", k, sw, sop, sb, e.we, e.op, e.b);
        end
        if (k > 0) begin
          n_cmp++;
          if (dcyc - prev != 3) begin n_bad++; $display("FAIL halt_cadence[%0d]: %0d cycles, expected 3", k, dcyc - prev); end
        end
        prev = dcyc;
      end
    end
    req_hi = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.imem_req !== 1'b0) req_hi++;
      @(negedge Clk);
    end
    n_cmp++;
    if (req_hi != 0 || pc !== 4'hC || halted !== 1'b1) begin
      n_bad++; $display("FAIL halt_hold: req high %0d cycles pc=%h halted=%b, expected 0 pc=c halted=1", req_hi, pc, halted);
    end
  endtask

  task automatic test_stall();
    bit ok; int stable, dcyc; logic sw; logic [3:0] sop, sb, saddr; exp_t e;
    do_reset();
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[0] = 8'h65; mem[1] = 8'h34; mem[2] = 8'h8F; mem[3] = 8'hF0;
    bus.imem_valid = 1'b1; bus.imem_data = 8'h6F;
    repeat (2) @(negedge Clk);
    bus.imem_valid = 1'b0; bus.imem_data = 8'h00;
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      fetch_one((k == 1) ? 4 : 0, (k == 0), 1'b0, ok, stable, dcyc, sw, sop, sb, saddr);
      n_cmp++;
      if (!ok || sb_q.size() == 0) begin
        n_bad++; $display("FAIL stall_fetch[%0d]: no fetch request within bound, req=%b expected 1", k, bus.imem_req);
      end else begin
        e = sb_q.pop_front();
        if ({saddr, pc, acc, halted, illegal} !== {e.addr, e.pc, e.acc, e.halted, e.illegal}) begin
          n_bad++; $display("FAIL stall_retire[%0d]: addr=%h pc=%h acc=%h h=%b i=%b, expected addr=%h pc=%h acc=%h h=%b i=%b",
                            k, saddr, pc, acc, halted, illegal, e.addr, e.pc, e.acc, e.halted, e.illegal);
        end
        n_cmp++;
        if ({sw, sop, sb} !== {e.we, e.op, e.b}) begin
          n_bad++; $display("FAIL stall_exec[%0d]: we=%b op=%h b=%h, expected we=%b op=%h b=%h", k, sw, sop, sb, e.we, e.op, e.b);
        end
        if (k == 1) begin
          n_cmp++;
          if (stable != 6) begin n_bad++; $display("FAIL stall_hold: req/addr stable %0d cycles, expected 6", stable); end
        end
      end
    end
  endtask

  task automatic test_wrap_illegal();
    bit ok; int stable, dcyc; logic sw; logic [3:0] sop, sb, saddr; exp_t e;
    do_reset();
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    pulse_start();
    for (int k = 0; k < 19; k++) begin
      if (k == 16) begin mem[0] = 8'h67; mem[1] = 8'hD3; mem[2] = 8'h11; end
      fetch_one(0, 1'b0, 1'b0, ok, stable, dcyc, sw, sop, sb, saddr);
      n_cmp++;
      if (!ok || sb_q.size() == 0) begin
        n_bad++; $display("FAIL wrap_fetch[%0d]: no fetch request within bound, req=%b expected 1", k, bus.imem_req);
      end else begin
        e = sb_q.pop_front();
        if ({saddr, pc, acc, halted, illegal} !== {e.addr, e.pc, e.acc, e.halted, e.illegal}) begin
          n_bad++; $display("FAIL wrap_retire[%0d]: addr=%h pc=%h acc=%h h=%b i=%b, expected addr=%h pc=%h acc=%h h=%b i=%b",
                            k, saddr, pc, acc, halted, illegal, e.addr, e.pc, e.acc, e.halted, e.illegal);
        end
        n_cmp++;
        if ({sw, sop, sb} !== {e.we, e.op, e.b}) begin
          n_bad++; $display("FAIL wrap_exec[%0d]: we=%b op=%h b=%h, expected we=%b op=%h b=%h", k, sw, sop, sb, e.we, e.op, e.b);
        end
      end
      if (k == 15) begin
        n_cmp++;
        if (pc !== 4'h0) begin n_bad++; $display("FAIL wrap_pc: pc=%h after 16 NOPs, expected 0", pc); end
      end
      if (k == 17) begin
        n_cmp++;
        if (illegal !== 1'b1 || acc !== 4'h7) begin
          n_bad++; $display("FAIL illegal_op: illegal=%b acc=%h, expected illegal=1 acc=7", illegal, acc);
        end
      end
    end
  endtask

  task automatic test_reset_exec();
    bit ok; int stable, dcyc, req_hi; logic sw; logic [3:0] sop, sb, saddr; exp_t e;
    do_reset();
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[0] = 8'h65; mem[1] = 8'h12;
    pulse_start();
    fetch_one(0, 1'b0, 1'b0, ok, stable, dcyc, sw, sop, sb, saddr);
    n_cmp++;
    if (!ok || sb_q.size() == 0) begin
      n_bad++; $display("FAIL rstx_fetch: no fetch request within bound, req=%b expected 1", bus.imem_req);
    end else begin
      e = sb_q.pop_front();
      if ({pc, acc} !== {e.pc, e.acc}) begin
        n_bad++; $display("FAIL rstx_ldi: pc=%h acc=%h, expected pc=%h acc=%h", pc, acc, e.pc, e.acc);
      end
    end
    fetch_one(0, 1'b0, 1'b1, ok, stable, dcyc, sw, sop, sb, saddr);
    n_cmp++;
    if (!ok || sw !== 1'b1 || {acc, pc, bus.flag_we, bus.alu_opcode, bus.imem_req, halted} !== 14'h0) begin
      n_bad++; $display("FAIL rst_in_exec: ok=%b exec_we=%b acc=%h pc=%h we=%b op=%h req=%b halted=%b, expected ok=1 exec_we=1 rest 0",
                        ok, sw, acc, pc, bus.flag_we, bus.alu_opcode, bus.imem_req, halted);
    end
    Rst = 1'b0;
    req_hi = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      if (bus.imem_req !== 1'b0) req_hi++;
    end
    n_cmp++;
    if (req_hi != 0) begin n_bad++; $display("FAIL rstx_idle: req high %0d cycles, expected 0", req_hi); end
    pulse_start();
    Rst = 1'b1; bus.imem_valid = 1'b1; bus.imem_data = 8'h6F;
    @(negedge Clk);
    Rst = 1'b0; bus.imem_valid = 1'b0; bus.imem_data = 8'h00;
    req_hi = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.imem_req !== 1'b0) req_hi++;
      @(negedge Clk);
    end
    n_cmp++;
    if (req_hi != 0 || acc !== 4'h0 || pc !== 4'h0) begin
      n_bad++; $display("FAIL rst_in_fetch: req high %0d cycles acc=%h pc=%h, expected 0 acc=0 pc=0", req_hi, acc, pc);
    end
  endtask

  initial begin
    Rst = 1'b1; Start = 1'b0; bus.imem_valid = 1'b0; bus.imem_data = 8'h00;
    test_reset();
    test_alu_carry();
    test_branch_halt();
    test_stall();
    test_wrap_illegal();
    test_reset_exec();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected bench to finish");
    $fatal(1);
  end

endmodule
